// File: rtl/snn_seq_ctrl.sv
// Sequencer for a spiking-network digit classifier.
// Loads a serial image byte by byte into a 1-bit pixel RAM, starts the
// inference core, waits for its result with a timeout, then sends one ASCII
// character back over the serial transmitter.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_rdy, rx_data       pending serial byte; rx_rdy_clr consumes it
//   core_addr             inference core's pixel RAM read address
//   ram_addr, ram_d,      pixel RAM port, shared between loader and core
//   ram_we
//   core_start            one-cycle inference start pulse
//   core_done, core_digit inference result strobe and classified digit
//   tx_busy, tx_start,    serial transmit handshake and byte
//   tx_data
//   digit                 last registered result
//   busy                  image loading or inference in flight
//   err                   last inference timed out or returned a bad digit
module snn_seq_ctrl #(
    parameter int unsigned IMG_BYTES   = 98,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       rx_rdy_clr,
    input  logic [9:0] core_addr,
    output logic [9:0] ram_addr,
    output logic       ram_d,
    output logic       ram_we,
    output logic       core_start,
    input  logic       core_done,
    input  logic [3:0] core_digit,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [3:0] digit,
    output logic       busy,
    output logic       err
);

    localparam int unsigned BC_W = $clog2(IMG_BYTES + 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        LOAD,
        WRITE,
        START,
        WAIT,
        TX
    } state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic [3:0]        digit_q, digit_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              err_q, err_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tmo_q      <= '0;
            digit_q    <= '0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            digit_q    <= digit_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

    // Next-state, datapath updates and strobes
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        digit_d    = digit_q;
        tx_data_d  = tx_data_q;
        err_d      = err_q;
        rx_rdy_clr = 1'b0;
        ram_addr   = core_addr;
        ram_d      = 1'b0;
        ram_we     = 1'b0;
        core_start = 1'b0;
        tx_start   = 1'b0;

        case (state_q)
            LOAD: begin
                ram_addr = 10'({byte_cnt_q, 3'b000});
                if (rx_rdy) begin
                    shift_d    = rx_data;
                    bit_cnt_d  = '0;
                    rx_rdy_clr = 1'b1;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                // Pixel address is byte_cnt*8 + bit_cnt, pixels LSB first
                ram_we    = 1'b1;
                ram_d     = shift_q[0];
                ram_addr  = 10'({byte_cnt_q, bit_cnt_q});
                shift_d   = {1'b0, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (byte_cnt_q == BC_W'(IMG_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = START;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                        state_d    = LOAD;
                    end
                end
            end
            START: begin
                core_start = 1'b1;
                tmo_d      = '0;
                err_d      = 1'b0;
                state_d    = WAIT;
            end
            WAIT: begin
                // core_done wins over a timeout expiring in the same cycle;
                // expiry happens in the TIMEOUT_CYC-th WAIT cycle
                if (core_done) begin
                    digit_d = core_digit;
                    if (core_digit <= 4'd9) begin
                        tx_data_d = 8'h30 + 8'(core_digit);
                    end else begin
                        tx_data_d = 8'h3F;
                        err_d     = 1'b1;
                    end
                    state_d = TX;
                end else if (tmo_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    tx_data_d = 8'h45;
                    err_d     = 1'b1;
                    state_d   = TX;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                end
            end
            TX: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign busy    = !((state_q == LOAD) && (byte_cnt_q == '0));
    assign digit   = digit_q;
    assign tx_data = tx_data_q;
    assign err     = err_q;

endmodule

// File: tb/tb_snn_seq_ctrl.sv
// Directed bench for snn_seq_ctrl: image loading, result reporting,
// transmit back-pressure, timeout and reset behaviour.
module tb_snn_seq_ctrl;

    localparam int unsigned IMG_BYTES = 98;
    localparam int unsigned TMO       = 16;
    localparam int          NPIX      = 784;
    // Expected ram_d sequence for byte 8'hA5, first written bit leftmost
    localparam logic [0:7]  A5_SEQ    = 8'b1010_0101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [9:0] core_addr = 10'h2AB;
    logic       core_done = 1'b0;
    logic [3:0] core_digit = 4'h0;
    logic       tx_busy = 1'b0;
    logic       rx_rdy_clr, ram_d, ram_we, core_start, tx_start, busy, err;
    logic [9:0] ram_addr;
    logic [7:0] tx_data;
    logic [3:0] digit;

    int vec_cnt = 0;
    int miss_cnt = 0;
    int cyc = 0;
    logic [7:0] pix [IMG_BYTES];

    // Monitor-owned counters
    int wr_cnt = 0, addr_bad = 0, data_bad = 0, cs_cnt = 0, tx_cnt = 0;
    int clr_cnt = 0, busy_low = 0, last_clr_cyc = 0, exp_addr = 0;

    snn_seq_ctrl #(.IMG_BYTES(IMG_BYTES), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .rx_rdy_clr(rx_rdy_clr), .core_addr(core_addr), .ram_addr(ram_addr),
        .ram_d(ram_d), .ram_we(ram_we), .core_start(core_start),
        .core_done(core_done), .core_digit(core_digit), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .digit(digit), .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-sequence scoreboard and event counters, sampled mid-cycle
    always @(negedge clk) begin
        logic [7:0] pb;
        if (!rst_n) begin
            exp_addr = 0;
        end else begin
            if (ram_we === 1'b1) begin
                wr_cnt++;
                pb = pix[7'(exp_addr / 8)];
                if (ram_addr !== 10'(exp_addr)) addr_bad++;
                if (ram_d !== pb[3'(exp_addr % 8)]) data_bad++;
                exp_addr = (exp_addr == NPIX - 1) ? 0 : exp_addr + 1;
            end
            if (core_start === 1'b1) cs_cnt++;
            if (tx_start === 1'b1) tx_cnt++;
            if (rx_rdy_clr === 1'b1) begin clr_cnt++; last_clr_cyc = cyc; end
            if (busy !== 1'b1) busy_low++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; rx_rdy = 1'b0; core_done = 1'b0; tx_busy = 1'b0;
        next_cyc();
        next_cyc();
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        rx_data = b;
        rx_rdy = 1'b1;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (rx_rdy_clr === 1'b1) begin
                ok = 1'b1;
                next_cyc();
                break;
            end
            next_cyc();
        end
        rx_rdy = 1'b0;
    endtask

    task automatic load_bytes(input int first, input int last, output bit ok);
        bit b_ok;
        ok = 1'b1;
        for (int i = first; i <= last; i++) begin
            send_byte(pix[7'(i)], b_ok);
            if (!b_ok) ok = 1'b0;
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            #1;
            if (core_start === 1'b1) begin ok = 1'b1; break; end
            next_cyc();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        vec_cnt++; if (rx_rdy_clr !== 1'b0) begin miss_cnt++; $display("FAIL reset rx_rdy_clr got %0h want 0", rx_rdy_clr); end
        vec_cnt++; if (ram_addr !== 10'h000) begin miss_cnt++; $display("FAIL reset ram_addr got %0h want 0", ram_addr); end
        vec_cnt++; if (ram_d !== 1'b0) begin miss_cnt++; $display("FAIL reset ram_d got %0h want 0", ram_d); end
        vec_cnt++; if (ram_we !== 1'b0) begin miss_cnt++; $display("FAIL reset ram_we got %0h want 0", ram_we); end
        vec_cnt++; if (core_start !== 1'b0) begin miss_cnt++; $display("FAIL reset core_start got %0h want 0", core_start); end
        vec_cnt++; if (tx_start !== 1'b0) begin miss_cnt++; $display("FAIL reset tx_start got %0h want 0", tx_start); end
        vec_cnt++; if (tx_data !== 8'h00) begin miss_cnt++; $display("FAIL reset tx_data got %0h want 0", tx_data); end
        vec_cnt++; if (digit !== 4'h0) begin miss_cnt++; $display("FAIL reset digit got %0h want 0", digit); end
        vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL reset busy got %0h want 0", busy); end
        vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL reset err got %0h want 0", err); end
        next_cyc();
        rst_n = 1'b1;
        next_cyc();
    endtask

    task automatic test_single_byte();
        bit ok;
        int c0 = clr_cnt;
        send_byte(8'hA5, ok);
        vec_cnt++; if (ok !== 1'b1) begin miss_cnt++; $display("FAIL single_byte consumed got %0b want 1", ok); end
        for (int b = 0; b < 8; b++) begin
            #1;
            vec_cnt++; if (ram_we !== 1'b1) begin miss_cnt++; $display("FAIL single_byte ram_we[%0d] got %0h want 1", b, ram_we); end
            vec_cnt++; if (ram_addr !== 10'(b)) begin miss_cnt++; $display("FAIL single_byte ram_addr[%0d] got %0d want %0d", b, ram_addr, b); end
            vec_cnt++; if (ram_d !== A5_SEQ[3'(b)]) begin miss_cnt++; $display("FAIL single_byte ram_d[%0d] got %0h want %0h", b, ram_d, A5_SEQ[3'(b)]); end
            next_cyc();
        end
        #1;
        vec_cnt++; if (ram_we !== 1'b0) begin miss_cnt++; $display("FAIL single_byte we_after got %0h want 0", ram_we); end
        vec_cnt++; if (ram_addr !== 10'd8) begin miss_cnt++; $display("FAIL single_byte load_addr got %0d want 8", ram_addr); end
        vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL single_byte busy got %0h want 1", busy); end
        vec_cnt++; if (clr_cnt - c0 !== 1) begin miss_cnt++; $display("FAIL single_byte clr_pulses got %0d want 1", clr_cnt - c0); end
        next_cyc();
        apply_reset();
    endtask

    task automatic test_full_image();
        bit ok, ok2;
        int w0 = wr_cnt, a0 = addr_bad, d0 = data_bad, bl0;
        core_addr = 10'h155;
        send_byte(pix[0], ok);
        bl0 = busy_low;
        load_bytes(1, 97, ok2);
        wait_start(ok);
        vec_cnt++; if ((ok & ok2) !== 1'b1) begin miss_cnt++; $display("FAIL full_image start_seen got %0b want 1", ok & ok2); end
        vec_cnt++; if (cyc - last_clr_cyc !== 9) begin miss_cnt++; $display("FAIL full_image start_latency got %0d want 9", cyc - last_clr_cyc); end
        vec_cnt++; if (wr_cnt - w0 !== NPIX) begin miss_cnt++; $display("FAIL full_image writes got %0d want %0d", wr_cnt - w0, NPIX); end
        vec_cnt++; if (addr_bad - a0 !== 0) begin miss_cnt++; $display("FAIL full_image addr_seq got %0d bad want 0", addr_bad - a0); end
        vec_cnt++; if (data_bad - d0 !== 0) begin miss_cnt++; $display("FAIL full_image data got %0d bad want 0", data_bad - d0); end
        vec_cnt++; if (busy_low - bl0 !== 0) begin miss_cnt++; $display("FAIL full_image busy_low got %0d cycles want 0", busy_low - bl0); end
        vec_cnt++; if (ram_addr !== 10'h155) begin miss_cnt++; $display("FAIL full_image start_mux got %0h want 155", ram_addr); end
        vec_cnt++; if (ram_we !== 1'b0) begin miss_cnt++; $display("FAIL full_image start_we got %0h want 0", ram_we); end
        next_cyc();
        #1;
        vec_cnt++; if (core_start !== 1'b0) begin miss_cnt++; $display("FAIL full_image start_width got %0h want 0", core_start); end
        vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL full_image wait_busy got %0h want 1", busy); end
        vec_cnt++; if (ram_addr !== 10'h155) begin miss_cnt++; $display("FAIL full_image wait_mux got %0h want 155", ram_addr); end
        next_cyc();
    endtask

    // Entered in WAIT; a byte pending there must wait for the next LOAD
    task automatic test_digit_ok();
        rx_data = pix[0];
        rx_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vec_cnt++; if (rx_rdy_clr !== 1'b0) begin miss_cnt++; $display("FAIL digit_ok wait_clr[%0d] got %0h want 0", k, rx_rdy_clr); end
            next_cyc();
        end
        core_done = 1'b1; core_digit = 4'd7; tx_busy = 1'b0;
        next_cyc();
        core_done = 1'b0; core_digit = 4'd0;
        #1;
        vec_cnt++; if (digit !== 4'd7) begin miss_cnt++; $display("FAIL digit_ok digit got %0h want 7", digit); end
        vec_cnt++; if (tx_data !== 8'h37) begin miss_cnt++; $display("FAIL digit_ok tx_data got %0h want 37", tx_data); end
        vec_cnt++; if (tx_start !== 1'b1) begin miss_cnt++; $display("FAIL digit_ok tx_start got %0h want 1", tx_start); end
        vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL digit_ok err got %0h want 0", err); end
        vec_cnt++; if (rx_rdy_clr !== 1'b0) begin miss_cnt++; $display("FAIL digit_ok tx_clr got %0h want 0", rx_rdy_clr); end
        next_cyc();
        #1;
        vec_cnt++; if (rx_rdy_clr !== 1'b1) begin miss_cnt++; $display("FAIL digit_ok load_clr got %0h want 1", rx_rdy_clr); end
        vec_cnt++; if (ram_addr !== 10'h000) begin miss_cnt++; $display("FAIL digit_ok load_addr got %0h want 0", ram_addr); end
        vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL digit_ok load_busy got %0h want 0", busy); end
        vec_cnt++; if (tx_start !== 1'b0) begin miss_cnt++; $display("FAIL digit_ok tx_width got %0h want 0", tx_start); end
        next_cyc();
        rx_rdy = 1'b0;
    endtask

    // Entered in WRITE of byte 0 of the next image
    task automatic test_done_ignored();
        bit ok, ok2;
        int t0 = tx_cnt;
        core_done = 1'b1; core_digit = 4'd3;
        next_cyc();
        core_done = 1'b0; core_digit = 4'd0;
        #1;
        vec_cnt++; if (digit !== 4'd7) begin miss_cnt++; $display("FAIL done_ignored digit got %0h want 7", digit); end
        vec_cnt++; if (ram_we !== 1'b1) begin miss_cnt++; $display("FAIL done_ignored still_writing got %0h want 1", ram_we); end
        next_cyc();
        load_bytes(1, 97, ok2);
        wait_start(ok);
        vec_cnt++; if ((ok & ok2) !== 1'b1) begin miss_cnt++; $display("FAIL done_ignored start_seen got %0b want 1", ok & ok2); end
        vec_cnt++; if (tx_cnt - t0 !== 0) begin miss_cnt++; $display("FAIL done_ignored tx_pulses got %0d want 0", tx_cnt - t0); end
        next_cyc();
    endtask

    task automatic test_invalid_digit();
        core_done = 1'b1; core_digit = 4'hC;
        next_cyc();
        core_done = 1'b0; core_digit = 4'h0;
        #1;
        vec_cnt++; if (tx_data !== 8'h3F) begin miss_cnt++; $display("FAIL invalid tx_data got %0h want 3f", tx_data); end
        vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL invalid err got %0h want 1", err); end
        vec_cnt++; if (digit !== 4'hC) begin miss_cnt++; $display("FAIL invalid digit got %0h want c", digit); end
        vec_cnt++; if (tx_start !== 1'b1) begin miss_cnt++; $display("FAIL invalid tx_start got %0h want 1", tx_start); end
        next_cyc();
        #1;
        vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL invalid err_hold got %0h want 1", err); end
        next_cyc();
    endtask

    task automatic test_tx_busy();
        bit ok, ok2;
        load_bytes(0, 97, ok2);
        wait_start(ok);
        vec_cnt++; if ((ok & ok2) !== 1'b1) begin miss_cnt++; $display("FAIL tx_busy start_seen got %0b want 1", ok & ok2); end
        next_cyc();
        #1;
        vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL tx_busy err_cleared got %0h want 0", err); end
        core_done = 1'b1; core_digit = 4'd9; tx_busy = 1'b1;
        next_cyc();
        core_done = 1'b0; core_digit = 4'd0;
        for (int k = 0; k < 5; k++) begin
            #1;
            vec_cnt++; if (tx_start !== 1'b0) begin miss_cnt++; $display("FAIL tx_busy held[%0d] got %0h want 0", k, tx_start); end
            next_cyc();
        end
        tx_busy = 1'b0;
        #1;
        vec_cnt++; if (tx_start !== 1'b1) begin miss_cnt++; $display("FAIL tx_busy release got %0h want 1", tx_start); end
        vec_cnt++; if (tx_data !== 8'h39) begin miss_cnt++; $display("FAIL tx_busy tx_data got %0h want 39", tx_data); end
        vec_cnt++; if (digit !== 4'd9) begin miss_cnt++; $display("FAIL tx_busy digit got %0h want 9", digit); end
        next_cyc();
        #1;
        vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL tx_busy idle got %0h want 0", busy); end
        next_cyc();
    endtask

    task automatic test_timeout();
        bit ok, ok2;
        int early = 0;
        load_bytes(0, 97, ok2);
        wait_start(ok);
        vec_cnt++; if ((ok & ok2) !== 1'b1) begin miss_cnt++; $display("FAIL timeout start_seen got %0b want 1", ok & ok2); end
        next_cyc();
        for (int k = 1; k <= 16; k++) begin
            #1;
            if (tx_start !== 1'b0 || err !== 1'b0) early++;
            next_cyc();
        end
        vec_cnt++; if (early !== 0) begin miss_cnt++; $display("FAIL timeout early got %0d cycles want 0", early); end
        #1;
        vec_cnt++; if (tx_data !== 8'h45) begin miss_cnt++; $display("FAIL timeout tx_data got %0h want 45", tx_data); end
        vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL timeout err got %0h want 1", err); end
        vec_cnt++; if (tx_start !== 1'b1) begin miss_cnt++; $display("FAIL timeout tx_start got %0h want 1", tx_start); end
        vec_cnt++; if (digit !== 4'd9) begin miss_cnt++; $display("FAIL timeout digit got %0h want 9", digit); end
        next_cyc();
    endtask

    task automatic test_timeout_tie();
        bit ok, ok2;
        load_bytes(0, 97, ok2);
        wait_start(ok);
        vec_cnt++; if ((ok & ok2) !== 1'b1) begin miss_cnt++; $display("FAIL tie start_seen got %0b want 1", ok & ok2); end
        next_cyc();
        repeat (15) next_cyc();
        core_done = 1'b1; core_digit = 4'd5;
        next_cyc();
        core_done = 1'b0; core_digit = 4'd0;
        #1;
        vec_cnt++; if (tx_data !== 8'h35) begin miss_cnt++; $display("FAIL tie tx_data got %0h want 35", tx_data); end
        vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL tie err got %0h want 0", err); end
        vec_cnt++; if (digit !== 4'd5) begin miss_cnt++; $display("FAIL tie digit got %0h want 5", digit); end
        vec_cnt++; if (tx_start !== 1'b1) begin miss_cnt++; $display("FAIL tie tx_start got %0h want 1", tx_start); end
        next_cyc();
    endtask

    task automatic test_reset_midload();
        bit ok, ok2, ok3;
        int s0 = cs_cnt, t0 = tx_cnt, a0 = addr_bad;
        load_bytes(0, 39, ok3);
        apply_reset();
        #1;
        vec_cnt++; if (ram_addr !== 10'h000) begin miss_cnt++; $display("FAIL reset_mid addr got %0h want 0", ram_addr); end
        vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL reset_mid busy got %0h want 0", busy); end
        next_cyc();
        load_bytes(0, 97, ok2);
        wait_start(ok);
        vec_cnt++; if ((ok & ok2 & ok3) !== 1'b1) begin miss_cnt++; $display("FAIL reset_mid start_seen got %0b want 1", ok & ok2 & ok3); end
        vec_cnt++; if (cs_cnt - s0 !== 0) begin miss_cnt++; $display("FAIL reset_mid early_start got %0d want 0", cs_cnt - s0); end
        vec_cnt++; if (addr_bad - a0 !== 0) begin miss_cnt++; $display("FAIL reset_mid addr_seq got %0d bad want 0", addr_bad - a0); end
        next_cyc();
        apply_reset();
        core_done = 1'b1; core_digit = 4'd2;
        next_cyc();
        core_done = 1'b0;
        repeat (20) next_cyc();
        vec_cnt++; if (tx_cnt - t0 !== 0) begin miss_cnt++; $display("FAIL reset_mid tx_pulses got %0d want 0", tx_cnt - t0); end
        vec_cnt++; if (cs_cnt - s0 !== 1) begin miss_cnt++; $display("FAIL reset_mid start_pulses got %0d want 1", cs_cnt - s0); end
        vec_cnt++; if (digit !== 4'd0) begin miss_cnt++; $display("FAIL reset_mid digit got %0h want 0", digit); end
    endtask

    initial begin
        for (int i = 0; i < int'(IMG_BYTES); i++) pix[7'(i)] = 8'(i * 37 + 5);
        pix[0] = 8'hA5;
        test_reset();
        test_single_byte();
        test_full_image();
        test_digit_ok();
        test_done_ignored();
        test_invalid_digit();
        test_tx_busy();
        test_timeout();
        test_timeout_tie();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
